nibble_addsub_arb: RTL
======================

Name: nibble_addsub_arb

Overview:
- Shares one nibble-wide (4-bit) add/sub stage between two requesters.
- Runs multi-nibble add or subtract operations LSB-nibble first, one nibble per clock, chaining the carry through a register.
- Sits between two client blocks and a single response consumer.
- All interfaces use valid/ready handshakes. Arbitration is round-robin unless the optional fixed-priority build is selected.

Parameters:
- NIBBLES, 4, number of nibbles per operand; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation is accepted this cycle.
- req0_sub  input  1  requester 0 op select: 0 = a+b, 1 = a-b.
- req0_a, req0_b  input  W  requester 0 operands.
- req1_valid, req1_ready, req1_sub, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  output  1  result is available.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  index of the requester that issued this result.
- rsp_result  output  W  sum or difference, modulo 2^W.
- rsp_carry  output  1  carry out of the MSB; for subtract, 1 = no borrow (a >= b unsigned).
- rsp_ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE.
  - rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, busy all = 0.
  - Round-robin pointer set so requester 0 is preferred next.
  - Nibble counter = 0; operand and carry registers cleared.
  - Any in-flight operation is discarded, with no response. Requesters must keep valid high to be re-accepted.
- reqN_ready is combinational and asserted only in IDLE, for at most one requester:
  - Only one valid: that requester gets ready.
  - Both valid: the requester not granted last gets ready.
  - reqN_ready is 0 in RUN and DONE.
- Accept = reqN_valid & reqN_ready at an edge. On accept:
  - Latch a, b XOR {W{sub}}, sub, id.
  - Carry register = sub.
  - Counter = 0; pointer records the winner.
  - state goes to RUN.
- RUN, each edge:
  - Nibble i = counter: compute {c, s} = a[i] + b'[i] + carry.
  - Write s into result nibble i; carry = c; counter + 1.
  - On the edge where counter == NIBBLES-1, go to DONE and capture the outputs:
    - rsp_carry = final carry.
    - rsp_ovf = (a[W-1] == b'[W-1]) & (result[W-1] != a[W-1]), using the latched, already-inverted b'.
- Latency: accept at edge k; rsp_valid high after edge k+NIBBLES (NIBBLES cycles spent in RUN).
- DONE:
  - rsp_valid = 1.
  - rsp_* held stable until rsp_valid & rsp_ready at an edge, then go to IDLE and rsp_valid drops.
- No accept while DONE, even in the same cycle as rsp_ready. Peak throughput is one operation per NIBBLES+2 cycles.
- Valid deasserted before accept: nothing latched, no state change.
- Operand changes while not ready are ignored; only values at the accept edge matter.
- rsp_ready high outside DONE has no effect.

Optional Feature:
- Macro: NIBBLE_ADDSUB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid; the pointer is not implemented. Requester 1 can starve; this is accepted.
- Undefined (default): round-robin as above.
- Reset values and latency are identical in both builds.

Test Plan:
- NIBBLES=4; req0 add a=0x1234 b=0x0FFF -> req0_ready 1 cycle; after 4 RUN cycles rsp_valid=1, rsp_result=0x2233, carry=0, ovf=0, id=0.
- req1 sub a=0x0005 b=0x0007 -> rsp_result=0xFFFE, carry=0 (borrow), ovf=0, id=1.
- Add 0x7FFF+0x0001 -> 0x8000, carry=0, ovf=1. Sub 0x8000-0x0001 -> 0x7FFF, carry=1, ovf=1. Add 0xFFFF+0x0001 -> 0x0000, carry=1, ovf=0.
- Both requesters valid continuously from reset, rsp_ready=1 -> rsp_id sequence 0,1,0,1. With NIBBLE_ADDSUB_FIXED_PRIO_EN -> 0,0,0,0.
- rsp_ready held 0 for 10 cycles in DONE -> rsp_* stable, both reqN_ready=0, no accept. Raise rsp_ready -> IDLE next edge, new accept on the following edge.
- rst pulsed during 2nd RUN cycle -> all outputs 0 immediately, without a clock edge. After release with req0 and req1 valid -> req0 accepted first and its full result returned correctly.

Source files
------------

// File: rtl/nibble_addsub_arb.sv
// Two-requester arbiter in front of a shared 4-bit add/sub stage that runs W-bit operations one nibble per clock.
// Build option: define NIBBLE_ADDSUB_FIXED_PRIO_EN for fixed priority (requester 0 wins), default is round-robin.
module nibble_addsub_arb #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_sub,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_sub,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*NIBBLES-1:0] rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_ovf,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_q;
    logic           carry_q;
    logic           id_q;
    logic [CW-1:0]  cnt_q;

    logic           grant0;
    logic           grant1;
    logic           accept;
    logic           sel_sub;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [3:0]     nib_s;
    logic           nib_c;
    logic [W-1:0]   res_d;

`ifdef NIBBLE_ADDSUB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`else
    logic ptr_q;  // last winner; the other requester is preferred on a tie

    assign grant0 = req0_valid & (~req1_valid | ptr_q);
    assign grant1 = req1_valid & (~req0_valid | ~ptr_q);
`endif

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign sel_sub = req1_ready ? req1_sub : req0_sub;
    assign sel_a   = req1_ready ? req1_a   : req0_a;
    assign sel_b   = req1_ready ? req1_b   : req0_b;

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // NOTE: every signal gets its default at the top of always_comb so no path can leave a latch behind.
    always_comb begin
        nib_a = a_q[4*cnt_q +: 4];
        nib_b = b_q[4*cnt_q +: 4];
        {nib_c, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        res_d = res_q;
        res_d[4*cnt_q +: 4] = nib_s;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            id_q       <= 1'b0;
            cnt_q      <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
`ifndef NIBBLE_ADDSUB_FIXED_PRIO_EN
            ptr_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Subtract is a + ~b + 1: invert b here, inject the +1 as carry-in.
                        a_q     <= sel_a;
                        b_q     <= sel_b ^ {W{sel_sub}};
                        carry_q <= sel_sub;
                        id_q    <= req1_ready;
                        cnt_q   <= '0;
                        state_q <= RUN;
`ifndef NIBBLE_ADDSUB_FIXED_PRIO_EN
                        ptr_q   <= req1_ready;
`endif
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= nib_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_NIB) begin
                        state_q    <= DONE;
                        rsp_id     <= id_q;
                        rsp_result <= res_d;
                        rsp_carry  <= nib_c;
                        rsp_ovf    <= (a_q[W-1] == b_q[W-1]) & (res_d[W-1] != a_q[W-1]);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
